// File: rtl/rng_pkg.sv
// rng_pkg: shared constants and types for the word-index random source.
//   LFSR_W   - LFSR state width
//   DEF_SEED - fallback seed, also used when a zero seed is supplied
//   TAP_MASK - feedback taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   lfsr_t   - LFSR state type
package rng_pkg;
  localparam int           LFSR_W   = 16;
  localparam logic [15:0]  DEF_SEED = 16'hACE1;
  localparam logic [15:0]  TAP_MASK = 16'hB400;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // Fibonacci feedback bit: XOR of the tapped state bits.
  function automatic logic lfsr_fb(input lfsr_t s);
    return ^(s & TAP_MASK);
  endfunction
endpackage

// File: rtl/random_number_generator_lfsr16.sv
// lfsr16: free-running 16-bit maximal-length Fibonacci LFSR.
// Ports:
//   clk     - clock, state advances on every rising edge outside reset
//   reset   - synchronous, active-high; loads the seed
//   i_seed  - reset / reload value (zero is replaced by DEF_SEED)
//   o_state - current LFSR state
// The all-zero state is a lockup point for an XOR LFSR; if it is ever
// reached the register reloads the seed on the next clock.
module lfsr16
  import rng_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  lfsr_t i_seed,
  output lfsr_t o_state
);
  lfsr_t r_state;
  lfsr_t w_seed;

  // A zero seed would lock the register immediately.
  assign w_seed  = (i_seed == '0) ? DEF_SEED : i_seed;
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= w_seed;
    else if (r_state == '0)
      r_state <= w_seed;
    else
      r_state <= {r_state[LFSR_W-2:0], lfsr_fb(r_state)};
  end
endmodule

// File: rtl/random_number_generator.sv
// random_number_generator: pseudo-random word-table index source.
// Captures an index in 0..RANGE-1 on each rising edge of grabWord.
// Ports:
//   clk        - single clock
//   reset      - synchronous, active-high
//   grabWord   - request strobe; its rising edge captures a new index
//   random_num - registered index, 0..RANGE-1
// Parameters: SEED (LFSR reset value), RANGE (number of indices, <=128 so
// the 8x7-bit product fits 15 bits), OUT_W (2**OUT_W >= RANGE).
// Build option: RNG_NO_REPEAT_EN - when defined, a capture that would repeat
// the current index takes the next index (wrapping RANGE-1 to 0) instead.
module random_number_generator
  import rng_pkg::*;
#(
  parameter lfsr_t SEED  = DEF_SEED,
  parameter int    RANGE = 100,
  parameter int    OUT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grabWord,
  output logic [OUT_W-1:0] random_num
);
  lfsr_t            w_lfsr;
  logic [14:0]      w_prod;
  logic [OUT_W-1:0] w_idx;
  logic [OUT_W-1:0] w_cap;
  logic             w_grab;
  logic             w_unused_lo;
  logic             r_grab_q;
  logic [OUT_W-1:0] r_num;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_seed  (SEED),
    .o_state (w_lfsr)
  );

  // Multiply-shift range reduction: top byte scaled into 0..RANGE-1.
  assign w_prod      = 15'(w_lfsr[15:8]) * 15'(RANGE);
  assign w_idx       = OUT_W'(w_prod >> 8);
  assign w_unused_lo = ^w_lfsr[7:0];

`ifdef RNG_NO_REPEAT_EN
  always_comb begin
    w_cap = w_idx;
    if (w_idx == r_num)
      w_cap = (w_idx == OUT_W'(RANGE-1)) ? '0 : w_idx + OUT_W'(1);
  end
`else
  assign w_cap = w_idx;
`endif

  // grab_q resets low, so a strobe already high at reset release still
  // counts as a rising edge.
  assign w_grab = grabWord & ~r_grab_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grab_q <= 1'b0;
      r_num    <= '0;
    end else begin
      r_grab_q <= grabWord;
      if (w_grab)
        r_num <= w_cap;
    end
  end

  assign random_num = r_num;
endmodule

// File: tb/tb_random_number_generator.sv
module tb_random_number_generator;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       grabWord = 1'b1;
  logic [6:0] random_num;

  random_number_generator #(.SEED(16'hACE1), .RANGE(100), .OUT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .grabWord   (grabWord),
    .random_num (random_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  num;
    logic [15:0] lfsr;
    bit          grab;
    bit          rst;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int total = 0;
  int bad   = 0;
  int last_cap = -1;
  bit seen [0:127];

  // reference state
  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_gq   = 1'b0;
  logic [6:0]  m_num  = 7'd0;

  // Drive one cycle; push the expected post-edge state. hn/hl >= 0 give
  // hand-computed values that override the reference model.
  task automatic cycle(input logic g, input logic r, input int hn, input int hl,
                       input string tag);
    exp_t e;
    logic [14:0] p;
    logic [6:0]  idx;
    bit ev;
    grabWord = g;
    reset    = r;
    @(posedge clk);
    ev = g && !m_gq && !r;
    if (r) begin
      m_lfsr = 16'hACE1; m_gq = 1'b0; m_num = 7'd0;
    end else begin
      if (ev) begin
        p   = {7'd0, m_lfsr[15:8]} * 15'd100;
        idx = p[14:8];
`ifdef RNG_NO_REPEAT_EN
        if (idx == m_num) idx = (idx == 7'd99) ? 7'd0 : idx + 7'd1;
`endif
        m_num = idx;
      end
      m_gq   = g;
      m_lfsr = (m_lfsr == 16'h0) ? 16'hACE1 :
               {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    e.num  = (hn >= 0) ? 7'(hn)  : m_num;
    e.lfsr = (hl >= 0) ? 16'(hl) : m_lfsr;
    e.grab = ev;
    e.rst  = r;
    e.tag  = tag;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: compare the DUT against the scoreboard head every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      total++;
      if (random_num !== me.num) begin
        bad++;
        $display("FAIL %s random_num got=%0d exp=%0d", me.tag, random_num, me.num);
      end
      total++;
      if (dut.w_lfsr !== me.lfsr) begin
        bad++;
        $display("FAIL %s lfsr got=%h exp=%h", me.tag, dut.w_lfsr, me.lfsr);
      end
      if (me.rst) last_cap = -1;
      if (me.grab) begin
        total++;
        if (random_num >= 7'd100) begin
          bad++;
          $display("FAIL %s range got=%0d exp=<100", me.tag, random_num);
        end
        seen[random_num] = 1'b1;
`ifdef RNG_NO_REPEAT_EN
        if (last_cap >= 0) begin
          total++;
          if (int'(random_num) == last_cap) begin
            bad++;
            $display("FAIL %s repeat got=%0d exp!=%0d", me.tag, random_num, last_cap);
          end
        end
`endif
        last_cap = int'(random_num);
      end
    end
  end

  initial begin
    int ncov;
    // reset held with strobe high: no capture
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 0, 'hACE1, "reset");
    // first cycle after reset: 0xAC*100>>8 = 67
    cycle(1'b1, 1'b0, 67, 'h59C3, "grab1");
    cycle(1'b0, 1'b0, 67, 'hB387, "low1");
    // 0xB3*100>>8 = 69
    cycle(1'b1, 1'b0, 69, 'h670F, "grab2");
    cycle(1'b0, 1'b0, 69, -1, "low2");
    // held strobe: one capture then stable
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, -1, -1, "held");
    // sweep at random spacing
    for (int k = 0; k < 10000; k++) begin
      int gap;
      gap = int'($urandom_range(1, 3));
      for (int j = 0; j < gap; j++) cycle(1'b0, 1'b0, -1, -1, "sweep_lo");
      cycle(1'b1, 1'b0, -1, -1, "sweep");
    end
    cycle(1'b0, 1'b0, -1, -1, "pre_rst");
    ncov = 0;
    for (int v = 0; v < 100; v++) if (seen[v]) ncov++;
    total++;
    if (ncov != 100) begin
      bad++;
      $display("FAIL coverage got=%0d exp=100", ncov);
    end
    // reset wins over a simultaneous grab edge, then sequence restarts
    cycle(1'b1, 1'b1, 0, 'hACE1, "rst_grab");
    cycle(1'b1, 1'b0, 67, 'h59C3, "restart");
    cycle(1'b0, 1'b0, 67, 'hB387, "restart_lo");
    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
